// File: rtl/fc4_cu_pkg.sv
// fc4_cu_pkg: shared definitions for the fully-connected control unit.
// Holds the FSM state encoding, default layer sizes and the address-width
// helper used to derive port widths from the layer parameters.
package fc4_cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fc4_state_e;

    localparam int unsigned DEF_IN_FEATURES  = 100;
    localparam int unsigned DEF_OUT_FEATURES = 10;
    localparam int unsigned DEF_MAC_LATENCY  = 4;

    // Address width for a memory of n entries; never narrower than one bit.
    function automatic int unsigned fc4_aw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_AW_IN  = fc4_aw(DEF_IN_FEATURES);
    localparam int unsigned DEF_AW_OUT = fc4_aw(DEF_OUT_FEATURES);
    localparam int unsigned DEF_AW_WM  = fc4_aw(DEF_IN_FEATURES * DEF_OUT_FEATURES);

endpackage

// File: rtl/fc4_cu_delay.sv
// fc_delay: parameterised shift register, WIDTH bits wide and DEPTH stages deep.
// Ports: i_clk, i_reset (async, active-low), i_d (input word), o_q (i_d delayed
// by DEPTH cycles). Used to align MAC strobes with the memory read latency.
module fc_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH*WIDTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) r_pipe <= '0;
                else          r_pipe <= i_d;
            end
        end else begin : g_many
            // Newest word enters at the bottom, oldest leaves at the top.
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) r_pipe <= '0;
                else          r_pipe <= {r_pipe[(DEPTH-1)*WIDTH-1:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_pipe[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/fc4_cu.sv
// fc4_cu: control unit for the fully-connected layer after conv stage 3.
// For each output neuron it streams the input vector and weight row to the
// MAC datapath, waits for the pipeline to drain, then writes one result.
// Ports:
//   i_clk, i_reset (async, active-low)
//   upstream : i_start_from_previous, o_end_to_previous, o_ifm_sel
//   reads    : o_ifm_enable_read/address, o_wm_enable_read/address,
//              o_bm_enable_read/address
//   datapath : o_mac_enable, o_acc_clear, o_relu_enable
//   output   : o_ofm_sel, o_ofm_enable_write, o_ofm_address_write
//   downstream: i_end_from_next, o_start_to_next (combinational)
module fc4_cu
    import fc4_cu_pkg::*;
#(
    parameter int unsigned IN_FEATURES  = DEF_IN_FEATURES,
    parameter int unsigned OUT_FEATURES = DEF_OUT_FEATURES,
    parameter int unsigned MAC_LATENCY  = DEF_MAC_LATENCY,
    parameter int unsigned USE_RELU     = 1,
    localparam int unsigned AW_IN  = fc4_aw(IN_FEATURES),
    localparam int unsigned AW_OUT = fc4_aw(OUT_FEATURES),
    localparam int unsigned AW_WM  = fc4_aw(IN_FEATURES * OUT_FEATURES)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start_from_previous,
    output logic              o_end_to_previous,
    output logic              o_ifm_sel,
    output logic              o_ifm_enable_read,
    output logic [AW_IN-1:0]  o_ifm_address_read,
    output logic              o_wm_enable_read,
    output logic [AW_WM-1:0]  o_wm_address_read,
    output logic              o_bm_enable_read,
    output logic [AW_OUT-1:0] o_bm_address_read,
    output logic              o_mac_enable,
    output logic              o_acc_clear,
    output logic              o_relu_enable,
    output logic              o_ofm_sel,
    output logic              o_ofm_enable_write,
    output logic [AW_OUT-1:0] o_ofm_address_write,
    input  logic              i_end_from_next,
    output logic              o_start_to_next
);

    localparam int unsigned DW = fc4_aw(MAC_LATENCY + 1);

    localparam logic [AW_IN-1:0]  IN_LAST    = AW_IN'(IN_FEATURES - 1);
    localparam logic [AW_OUT-1:0] OUT_LAST   = AW_OUT'(OUT_FEATURES - 1);
    localparam logic [AW_WM-1:0]  WM_LAST    = AW_WM'(IN_FEATURES * OUT_FEATURES - 1);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(MAC_LATENCY);

    fc4_state_e        r_state;
    fc4_state_e        w_state_next;
    logic [AW_IN-1:0]  r_in_cnt;
    logic [AW_OUT-1:0] r_out_cnt;
    logic [AW_WM-1:0]  r_wm_cnt;
    logic [DW-1:0]     r_drain_cnt;
    logic              r_ifm_sel;
    logic              r_ofm_sel;

    logic              w_start_ok;
    logic              w_handoff;
    logic              w_in_last;
    logic              w_out_last;
    logic              w_wm_last;
    logic              w_drain_last;
    logic              w_ifm_rd;
    logic              w_first_rd;
    logic [1:0]        w_dly_d;
    logic [1:0]        w_dly_q;

    assign w_start_ok   = (r_state == ST_IDLE) && i_start_from_previous;
    assign w_handoff    = (r_state == ST_DONE) && i_end_from_next;
    assign w_in_last    = (r_in_cnt == IN_LAST);
    assign w_out_last   = (r_out_cnt == OUT_LAST);
    assign w_wm_last    = (r_wm_cnt == WM_LAST);
    assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
    assign w_ifm_rd     = (r_state == ST_READ);
    assign w_first_rd   = w_ifm_rd && (r_in_cnt == '0);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start_from_previous) w_state_next = ST_READ;
            ST_READ:  if (w_in_last)             w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_last)          w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = w_out_last ? ST_DONE : ST_READ;
            ST_DONE:  if (i_end_from_next)       w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output decode; addresses follow the counters directly.
    always_comb begin
        o_end_to_previous   = 1'b0;
        o_ifm_enable_read   = 1'b0;
        o_wm_enable_read    = 1'b0;
        o_bm_enable_read    = 1'b0;
        o_relu_enable       = 1'b0;
        o_ofm_enable_write  = 1'b0;
        o_start_to_next     = 1'b0;
        o_ifm_address_read  = r_in_cnt;
        o_wm_address_read   = r_wm_cnt;
        o_bm_address_read   = r_out_cnt;
        o_ofm_address_write = r_out_cnt;
        case (r_state)
            ST_IDLE: o_end_to_previous = 1'b1;
            ST_READ: begin
                o_ifm_enable_read = 1'b1;
                o_wm_enable_read  = 1'b1;
                o_bm_enable_read  = w_first_rd;
            end
            ST_WRITE: begin
                o_ofm_enable_write = 1'b1;
                o_relu_enable      = (USE_RELU != 0);
            end
            ST_DONE: begin
                o_end_to_previous = 1'b1;
                o_start_to_next   = i_end_from_next;
            end
            default: ;
        endcase
    end

    // Loop counters: cleared on an accepted start, each wraps at its terminal value.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wm_cnt    <= '0;
            r_drain_cnt <= '0;
        end else if (w_start_ok) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wm_cnt    <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_READ: begin
                    r_in_cnt <= w_in_last ? '0 : r_in_cnt + AW_IN'(1);
                    r_wm_cnt <= w_wm_last ? '0 : r_wm_cnt + AW_WM'(1);
                end
                ST_DRAIN: r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + DW'(1);
                ST_WRITE: r_out_cnt   <= w_out_last ? '0 : r_out_cnt + AW_OUT'(1);
                default: ;
            endcase
        end
    end

    // Ping-pong bank selects.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ifm_sel <= 1'b0;
            r_ofm_sel <= 1'b0;
        end else begin
            if (w_start_ok) r_ifm_sel <= ~r_ifm_sel;
            if (w_handoff)  r_ofm_sel <= ~r_ofm_sel;
        end
    end

    assign o_ifm_sel = r_ifm_sel;
    assign o_ofm_sel = r_ofm_sel;

    // One cycle of memory latency between read strobe and operand at the MAC.
    assign w_dly_d = {w_ifm_rd, w_first_rd};

    fc_delay #(
        .WIDTH (2),
        .DEPTH (1)
    ) u_strobe_dly (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (w_dly_d),
        .o_q     (w_dly_q)
    );

    assign o_mac_enable = w_dly_q[1];
    assign o_acc_clear  = w_dly_q[0];

endmodule

// File: tb/tb_fc4_cu.sv
// tb_fc4_cu: randomized bench for fc4_cu. Two instances (ReLU on and off) see
// the same stimulus; a cycle-count reference model predicts every strobe,
// address and bank select from the elapsed time since the accepted start.
module tb_fc4_cu;

    localparam int unsigned NIN    = 100;
    localparam int unsigned NOUT   = 10;
    localparam int unsigned LAT    = 4;
    localparam int unsigned NEURON = NIN + LAT + 2;
    localparam int unsigned RUNLEN = NOUT * NEURON;
    localparam int unsigned CYCLES = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, efn;

    logic a_e2p, a_isel, a_ifm_en, a_wm_en, a_bm_en, a_mac, a_acc, a_relu;
    logic a_osel, a_we, a_s2n;
    logic [6:0] a_ifm_addr;
    logic [9:0] a_wm_addr;
    logic [3:0] a_bm_addr, a_ofm_addr;

    logic b_e2p, b_isel, b_ifm_en, b_wm_en, b_bm_en, b_mac, b_acc, b_relu;
    logic b_osel, b_we, b_s2n;
    logic [6:0] b_ifm_addr;
    logic [9:0] b_wm_addr;
    logic [3:0] b_bm_addr, b_ofm_addr;

    fc4_cu #(.USE_RELU(1)) u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_start_from_previous(start),
        .o_end_to_previous(a_e2p), .o_ifm_sel(a_isel),
        .o_ifm_enable_read(a_ifm_en), .o_ifm_address_read(a_ifm_addr),
        .o_wm_enable_read(a_wm_en), .o_wm_address_read(a_wm_addr),
        .o_bm_enable_read(a_bm_en), .o_bm_address_read(a_bm_addr),
        .o_mac_enable(a_mac), .o_acc_clear(a_acc), .o_relu_enable(a_relu),
        .o_ofm_sel(a_osel), .o_ofm_enable_write(a_we),
        .o_ofm_address_write(a_ofm_addr), .i_end_from_next(efn),
        .o_start_to_next(a_s2n)
    );

    fc4_cu #(.USE_RELU(0)) u_dut_nr (
        .i_clk(clk), .i_reset(rst_n), .i_start_from_previous(start),
        .o_end_to_previous(b_e2p), .o_ifm_sel(b_isel),
        .o_ifm_enable_read(b_ifm_en), .o_ifm_address_read(b_ifm_addr),
        .o_wm_enable_read(b_wm_en), .o_wm_address_read(b_wm_addr),
        .o_bm_enable_read(b_bm_en), .o_bm_address_read(b_bm_addr),
        .o_mac_enable(b_mac), .o_acc_clear(b_acc), .o_relu_enable(b_relu),
        .o_ofm_sel(b_osel), .o_ofm_enable_write(b_we),
        .o_ofm_address_write(b_ofm_addr), .i_end_from_next(efn),
        .o_start_to_next(b_s2n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 running (k cycles since accepted start), 2 done.
    int mode = 0;
    int k    = 0;
    int done_cyc = 0;
    int run_cnt  = 0;
    int efn_mode = 0;
    bit m_isel = 1'b0;
    bit m_osel = 1'b0;
    bit did_rst = 1'b0;
    int exp_writes = 0, got_writes_a = 0, got_writes_b = 0;
    int exp_s2n = 0, got_s2n = 0;

    task automatic check_cycle();
        logic ifm, bm, mac, acc, we, s2n, e2p;
        int n, p;
        logic [10:0] ea, eb;
        logic [24:0] eaddr, mask;
        ifm = 0; bm = 0; mac = 0; acc = 0; we = 0; s2n = 0; e2p = 0;
        n = 0; p = 0;
        if (mode == 1) begin
            n   = k / NEURON;
            p   = k % NEURON;
            ifm = (p < NIN);
            bm  = (p == 0);
            mac = (p >= 1) && (p <= NIN);
            acc = (p == 1);
            we  = (p == NEURON - 1);
        end else if (mode == 2) begin
            e2p = 1;
            s2n = efn;
        end else begin
            e2p = 1;
        end
        ea = {ifm, ifm, bm, mac, acc, we,   we, s2n, e2p, m_isel, m_osel};
        eb = {ifm, ifm, bm, mac, acc, 1'b0, we, s2n, e2p, m_isel, m_osel};
        eaddr = {7'(p), 10'(n * NIN + p), 4'(n), 4'(n)};
        mask  = {{7{ifm}}, {10{ifm}}, {4{bm}}, {4{we}}};
        chk("strobes_relu1", 32'({a_ifm_en, a_wm_en, a_bm_en, a_mac, a_acc, a_relu,
                                  a_we, a_s2n, a_e2p, a_isel, a_osel}), 32'(ea));
        chk("strobes_relu0", 32'({b_ifm_en, b_wm_en, b_bm_en, b_mac, b_acc, b_relu,
                                  b_we, b_s2n, b_e2p, b_isel, b_osel}), 32'(eb));
        chk("addr_relu1", 32'({a_ifm_addr, a_wm_addr, a_bm_addr, a_ofm_addr} & mask),
            32'(eaddr & mask));
        chk("addr_relu0", 32'({b_ifm_addr, b_wm_addr, b_bm_addr, b_ofm_addr} & mask),
            32'(eaddr & mask));
        if (we)    exp_writes++;
        if (s2n)   exp_s2n++;
        if (a_we)  got_writes_a++;
        if (b_we)  got_writes_b++;
        if (a_s2n) got_s2n++;
    endtask

    task automatic check_reset();
        chk("rst_strobes_relu1", 32'({a_ifm_en, a_wm_en, a_bm_en, a_mac, a_acc, a_relu,
                                      a_we, a_s2n, a_e2p, a_isel, a_osel}), 32'h004);
        chk("rst_strobes_relu0", 32'({b_ifm_en, b_wm_en, b_bm_en, b_mac, b_acc, b_relu,
                                      b_we, b_s2n, b_e2p, b_isel, b_osel}), 32'h004);
        chk("rst_addr", 32'({a_ifm_addr, a_wm_addr, a_bm_addr, a_ofm_addr}), 32'h0);
    endtask

    task automatic advance();
        case (mode)
            0: if (start) begin
                m_isel = ~m_isel;
                mode = 1;
                k = 0;
                run_cnt++;
                efn_mode = (run_cnt <= 2) ? 0 : (run_cnt == 3) ? 2 : int'($urandom_range(0, 2));
            end
            1: begin
                k++;
                if (k == int'(RUNLEN)) begin
                    mode = 2;
                    done_cyc = 0;
                end
            end
            default: begin
                if (efn) begin
                    m_osel = ~m_osel;
                    mode = 0;
                end else begin
                    done_cyc++;
                end
            end
        endcase
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        efn   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int cyc = 0; cyc < int'(CYCLES); cyc++) begin
            start = ($urandom_range(0, 7) == 0);
            case (efn_mode)
                0:       efn = 1'b1;
                1:       efn = ($urandom_range(0, 2) == 0);
                default: efn = (mode == 2) && (done_cyc >= 50);
            endcase
            @(negedge clk);
            check_cycle();
            if (!did_rst && mode == 1 && k == 37) begin
                // Asynchronous reset in the middle of the first READ.
                did_rst = 1'b1;
                rst_n = 1'b0;
                start = 1'b0;
                #1 check_reset();
                mode = 0;
                k = 0;
                m_isel = 1'b0;
                m_osel = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                continue;
            end
            advance();
            @(posedge clk);
            #1;
        end
        chk("write_count_relu1", 32'(got_writes_a), 32'(exp_writes));
        chk("write_count_relu0", 32'(got_writes_b), 32'(exp_writes));
        chk("start_to_next_count", 32'(got_s2n), 32'(exp_s2n));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc4_cu.md
# fc4_cu

Control unit for the fully-connected layer placed directly downstream of the third convolution stage. It consumes the IN_FEATURES-element feature vector that the convolution stage writes into a ping-pong buffer. For each output neuron it streams the vector and the matching weight row into the MAC datapath, then writes the result into its own ping-pong output buffer. It uses the same start/end handshake as the other stages on both sides.

## Interface
Parameters:
- IN_FEATURES, 100: length of the input vector, equal to the conv stage's filter count.
- OUT_FEATURES, 10: number of output neurons.
- MAC_LATENCY, 4: pipeline depth of the multiply-accumulate datapath, in cycles.
- USE_RELU, 1: selects whether relu_enable is asserted with each write.
- Derived: AW_IN = $clog2(IN_FEATURES), AW_OUT = $clog2(OUT_FEATURES), AW_WM = $clog2(IN_FEATURES*OUT_FEATURES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start_from_previous  in  1  pulse: the input bank is full.
- end_to_previous  out  1  high when this block can accept a start.
- ifm_sel  out  1  input bank being read; toggles on each accepted start.
- ifm_enable_read  out  1  input read strobe.
- ifm_address_read  out  AW_IN  input read address.
- wm_enable_read  out  1  weight read strobe.
- wm_address_read  out  AW_WM  weight read address.
- bm_enable_read  out  1  bias read strobe.
- bm_address_read  out  AW_OUT  bias address, equal to the current neuron index.
- mac_enable  out  1  MAC operand-valid strobe.
- acc_clear  out  1  loads bias plus the first product into the accumulator.
- relu_enable  out  1  apply ReLU to the value being written.
- ofm_sel  out  1  output bank being written; toggles on start_to_next.
- ofm_enable_write  out  1  output write strobe.
- ofm_address_write  out  AW_OUT  output write address.
- end_from_next  in  1  downstream has finished with its bank.
- start_to_next  out  1  one-cycle pulse: output bank complete.

## Operation
State machine:
- IDLE:
  - end_to_previous = 1.
  - On start_from_previous: toggle ifm_sel, clear all counters, go to READ.
- READ:
  - Lasts IN_FEATURES cycles; in_cnt runs 0..IN_FEATURES-1.
  - ifm_enable_read = wm_enable_read = 1.
  - ifm_address_read = in_cnt.
  - wm_address_read is a running counter; it is not reset between neurons. Address = out_cnt*IN_FEATURES + in_cnt.
  - bm_enable_read = 1 only when in_cnt == 0.
  - After the last element, go to DRAIN.
- DRAIN:
  - Lasts MAC_LATENCY+1 cycles (1 cycle of memory latency plus the MAC pipeline), counted by drain_cnt.
  - Then go to WRITE.
- WRITE:
  - One cycle: ofm_enable_write = 1, ofm_address_write = out_cnt, relu_enable = USE_RELU.
  - If out_cnt == OUT_FEATURES-1, go to DONE. Otherwise increment out_cnt and go to READ.
- DONE:
  - end_to_previous = 1; the input bank is released.
  - When end_from_next is high: start_to_next = 1 for that cycle, toggle ofm_sel, go to IDLE.
  - Otherwise hold in DONE.

Datapath strobes:
- mac_enable = ifm_enable_read delayed by 1 cycle.
- acc_clear = (READ && in_cnt == 0) delayed by 1 cycle.

Handshake and counter rules:
- start_from_previous is ignored in every state except IDLE. A start that arrives in DONE is lost. Upstream only issues start while end_to_previous is high, and end_to_previous is high in DONE as well as IDLE, so upstream holds or re-issues start until the block reaches IDLE.
- in_cnt and out_cnt wrap to 0 at their terminal values. No counter exceeds its terminal value.

## Timing
- Reset values (asserted, or mid-operation):
  - Every output is 0 except end_to_previous = 1.
  - State returns to IDLE.
  - ifm_sel = ofm_sel = 0; all counters = 0.
- Start accepted at edge T: the first read strobe appears in cycle T+1.
- Each neuron takes IN_FEATURES + MAC_LATENCY + 2 cycles (106 with the defaults).
- A full vector takes OUT_FEATURES times that (1060 cycles with the defaults) before DONE.
- start_to_next is combinational from DONE && end_from_next. If end_from_next is already high on entry to DONE, start_to_next pulses in the first DONE cycle.
- ofm_enable_write never overlaps ifm_enable_read.

## Structure
- Shared package holds:
  - the state encoding: IDLE=0, READ=1, DRAIN=2, WRITE=3, DONE=4, 3 bits;
  - the derived width constants.
- One sub-module: fc_delay, a parameterised shift register (width, depth). It generates mac_enable and acc_clear.

## Test plan
- Reset mid-READ (in_cnt = 37): all counters clear, end_to_previous = 1, every strobe is 0 in the next cycle.
- One start with end_from_next held high:
  - exactly 10 ofm_enable_write pulses, at addresses 0..9, spaced 106 cycles apart;
  - wm_address_read reaches 999;
  - one start_to_next pulse;
  - ifm_sel and ofm_sel both equal 1 afterwards.
- Per neuron: acc_clear is high on exactly one cycle, coincident with the first mac_enable; bm_address_read = out_cnt.
- end_from_next held low for 50 cycles after DONE: block stays in DONE, start_to_next stays 0. After end_from_next rises, one start_to_next pulse.
- start_from_previous pulsed during READ: ignored, ifm_sel unchanged. A second start issued in IDLE is accepted and ifm_sel toggles back to 0.
- USE_RELU = 0: relu_enable stays 0 for the whole run; write count is unchanged.
